// File: rtl/mmbus_pkg.sv
// Shared definitions for the port-B bus arbiter: FSM encoding, idle address
// and the MMIO device addresses used by the bus and its benches.
package mmbus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SLOT = 2'd1,
    ST_RESP = 2'd2
  } mmbus_state_e;

  // No device decodes this address, so an idle bus can never strobe anything.
  localparam logic [31:0] IDLE_ADDR_DEFAULT = 32'hFFFF_FFFF;

  localparam logic [31:0] MMIO_UART_TX     = 32'd65537;
  localparam logic [31:0] MMIO_UART_RX     = 32'd65538;
  localparam logic [31:0] MMIO_UART_STATUS = 32'd65539;
  localparam logic [31:0] MMIO_LED         = 32'd65540;
  localparam logic [31:0] MMIO_VGADUMP     = 32'd65599;

endpackage

// File: rtl/mmbus_rr_pick.sv
// Combinational round-robin picker: the first requester after ptr (wrapping)
// wins. Produces both a one-hot grant and the binary index of the winner.
module mmbus_rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            valid,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx
);

  // Walk candidates from lowest to highest priority so the last hit wins.
  always_comb begin
    valid = 1'b0;
    grant = '0;
    idx   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && (i == (int'(ptr) + k) % NREQ)) begin
          valid    = 1'b1;
          grant    = '0;
          grant[i] = 1'b1;
          idx      = IW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/mmbus_arbiter.sv
// Round-robin arbiter for the shared port-B data bus: one bus slot per
// request, registered read data / error capture, one-cycle one-hot ack.
//
// Handshake: a requester raises req with addr/wdata/we and holds all of them
// stable up to and including the cycle in which its ack bit is high; req still
// high in that ack cycle is taken as a fresh request in the following cycle.
module mmbus_arbiter
  import mmbus_pkg::*;
#(
  parameter int          NREQ      = 2,
  parameter logic [31:0] IDLE_ADDR = IDLE_ADDR_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*32-1:0]   addr,
  input  logic [NREQ*32-1:0]   wdata,
  input  logic [NREQ-1:0]      we,
  output logic [NREQ-1:0]      ack,
  output logic [31:0]          rdata,
  output logic                 err,
  output logic [31:0]          addr_b,
  output logic [31:0]          data_b_in,
  output logic [31:0]          data_b_we,
  input  logic [31:0]          data_b,
  input  logic                 strobe_b,
  output mmbus_state_e         dbg_state
);

  localparam int IW = (NREQ > 2) ? 2 : 1;

  mmbus_state_e    state_q, state_d;
  logic [IW-1:0]   ptr_q;
  logic [NREQ-1:0] gnt_q;

  logic            pick_valid;
  logic [NREQ-1:0] pick_grant;
  logic [IW-1:0]   pick_idx;
  logic [31:0]     sel_addr, sel_wdata;
  logic            sel_we;
  logic            load_slot, capture;

  mmbus_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_grant[i]) begin
        sel_addr  = addr[32*i +: 32];
        sel_wdata = wdata[32*i +: 32];
        sel_we    = we[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pick_valid) state_d = ST_SLOT;
      ST_SLOT: state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    load_slot = (state_q == ST_IDLE) && pick_valid;
    capture   = (state_q == ST_SLOT);
    dbg_state = state_q;
  end

  // Bus is driven only during SLOT; every other state shows the idle values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q     <= IW'(NREQ - 1);
      gnt_q     <= '0;
      ack       <= '0;
      rdata     <= '0;
      err       <= 1'b0;
      addr_b    <= IDLE_ADDR;
      data_b_in <= '0;
      data_b_we <= '0;
    end else if (load_slot) begin
      ptr_q     <= pick_idx;
      gnt_q     <= pick_grant;
      addr_b    <= sel_addr;
      data_b_in <= sel_wdata;
      data_b_we <= {31'b0, sel_we};
    end else if (capture) begin
      rdata     <= strobe_b ? data_b : '0;
      err       <= ~strobe_b;
      ack       <= gnt_q;
      addr_b    <= IDLE_ADDR;
      data_b_in <= '0;
      data_b_we <= '0;
    end else begin
      ack       <= '0;
    end
  end

endmodule

// File: tb/tb_mmbus_arbiter.sv
// Bench for mmbus_arbiter: scripted requesters, a port-B device model, and a
// transaction-level reference that predicts every output cycle by cycle.
module tb_mmbus_arbiter;
  import mmbus_pkg::*;

  localparam int NREQ = 2;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic        w;
    int          gap;
    logic        drop;
  } txn_t;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req, we, ack;
  logic [NREQ*32-1:0] addr, wdata;
  logic [31:0]        rdata, addr_b, data_b_in, data_b_we, data_b;
  logic               err, strobe_b;
  mmbus_state_e       dbg_state;

  mmbus_arbiter #(.NREQ(NREQ), .IDLE_ADDR(32'hFFFF_FFFF)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .addr      (addr),
    .wdata     (wdata),
    .we        (we),
    .ack       (ack),
    .rdata     (rdata),
    .err       (err),
    .addr_b    (addr_b),
    .data_b_in (data_b_in),
    .data_b_we (data_b_we),
    .data_b    (data_b),
    .strobe_b  (strobe_b),
    .dbg_state (dbg_state)
  );

  // ---------------- port-B devices ----------------
  function automatic logic [31:0] soc_init(input logic [3:0] k);
    return (k == 4'd5) ? 32'hDEAD_BEEF : {16'h5A00, 12'h000, k};
  endfunction

  logic        env_clear;
  logic [31:0] env_soc [16];
  logic [15:0] env_wr;
  logic [31:0] env_led;
  int          we_cnt;

  always_comb begin
    strobe_b = 1'b0;
    data_b   = 32'hBAD0_BAD0;
    if (addr_b < 32'd16) begin
      strobe_b = 1'b1;
      data_b   = env_wr[addr_b[3:0]] ? env_soc[addr_b[3:0]] : soc_init(addr_b[3:0]);
    end else if (addr_b >= MMIO_UART_TX && addr_b <= MMIO_UART_STATUS) begin
      strobe_b = 1'b1;
      data_b   = 32'h0000_0100 + (addr_b - MMIO_UART_TX);
    end else if (addr_b == MMIO_LED) begin
      strobe_b = 1'b1;
      data_b   = env_led;
    end else if (addr_b == MMIO_VGADUMP) begin
      strobe_b = 1'b1;
      data_b   = 32'h0;
    end
  end

  always @(posedge clk) begin
    if (env_clear) begin
      env_wr  <= '0;
      env_led <= '0;
      we_cnt  <= 0;
    end else if (data_b_we != 32'd0) begin
      we_cnt <= we_cnt + 1;
      if (addr_b < 32'd16) begin
        env_soc[addr_b[3:0]] <= data_b_in;
        env_wr[addr_b[3:0]]  <= 1'b1;
      end else if (addr_b == MMIO_LED) begin
        env_led <= data_b_in;
      end
    end
  end

  // ---------------- reference model state ----------------
  logic [31:0] ref_soc [16];
  logic [15:0] ref_wr;
  logic [31:0] ref_led;

  txn_t sq  [NREQ][$];
  txn_t cur [NREQ];
  logic pend    [NREQ];
  logic dropped [NREQ];
  int   hold    [NREQ];

  int          cyc, m_free, m_ptr, win, slot_cyc, ack_cyc;
  txn_t        slot_t;
  logic [31:0] exp_rd, cur_rd;
  logic        exp_e, cur_e;
  int          ack_log [$];
  int          ack_t   [$];

  int checks, errors;

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s @cyc %0d: observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // Device behaviour at transaction level: returns what the slot reads back.
  task automatic ref_access(input txn_t t, output logic [31:0] rd, output logic e);
    rd = 32'd0;
    e  = 1'b1;
    if (t.a < 32'd16) begin
      e  = 1'b0;
      rd = ref_wr[t.a[3:0]] ? ref_soc[t.a[3:0]] : soc_init(t.a[3:0]);
      if (t.w) begin
        ref_soc[t.a[3:0]] = t.d;
        ref_wr[t.a[3:0]]  = 1'b1;
      end
    end else if (t.a inside {[MMIO_UART_TX:MMIO_UART_STATUS]}) begin
      e  = 1'b0;
      rd = 32'h0000_0100 + (t.a - MMIO_UART_TX);
    end else if (t.a == MMIO_LED) begin
      e  = 1'b0;
      rd = ref_led;
      if (t.w) ref_led = t.d;
    end else if (t.a == MMIO_VGADUMP) begin
      e  = 1'b0;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREQ; i++) begin
      pend[i]    = 1'b0;
      dropped[i] = 1'b0;
      hold[i]    = 0;
      sq[i].delete();
    end
    m_ptr    = NREQ - 1;
    m_free   = cyc;
    win      = 0;
    slot_cyc = -10;
    ack_cyc  = -10;
    cur_rd   = 32'd0;
    cur_e    = 1'b0;
    ack_log.delete();
    ack_t.delete();
  endtask

  // Drive requesters for this cycle and let the model arbitrate.
  task automatic cycle_begin();
    int w;
    for (int i = 0; i < NREQ; i++) begin
      if (pend[i] && ack_cyc == cyc - 1 && win == i) begin
        pend[i]    = 1'b0;
        dropped[i] = 1'b0;
      end
      if (!pend[i] && sq[i].size() > 0) begin
        if (hold[i] < sq[i][0].gap) hold[i]++;
        else begin
          cur[i]  = sq[i].pop_front();
          pend[i] = 1'b1;
          hold[i] = 0;
        end
      end
      req[i] = pend[i] && !dropped[i];
      if (req[i]) begin
        addr[32*i +: 32]  = cur[i].a;
        wdata[32*i +: 32] = cur[i].d;
        we[i]             = cur[i].w;
      end else begin
        addr[32*i +: 32]  = $urandom;
        wdata[32*i +: 32] = $urandom;
        we[i]             = 1'($urandom);
      end
    end
    if (cyc >= m_free && req != '0) begin
      w = 0;
      for (int k = NREQ; k >= 1; k--)
        if (req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      m_ptr    = w;
      win      = w;
      slot_t   = cur[w];
      ref_access(cur[w], exp_rd, exp_e);
      slot_cyc = cyc + 1;
      ack_cyc  = cyc + 2;
      m_free   = cyc + 3;
      if (cur[w].drop) dropped[w] = 1'b1;
    end
  endtask

  task automatic cycle_check();
    if (cyc == ack_cyc) begin
      cur_rd = exp_rd;
      cur_e  = exp_e;
    end
    chk("ack", 32'(ack), (cyc == ack_cyc) ? (32'd1 << win) : 32'd0);
    chk("addr_b", addr_b, (cyc == slot_cyc) ? slot_t.a : 32'hFFFF_FFFF);
    chk("data_b_in", data_b_in, (cyc == slot_cyc) ? slot_t.d : 32'd0);
    chk("data_b_we", data_b_we, (cyc == slot_cyc) ? {31'd0, slot_t.w} : 32'd0);
    chk("rdata", rdata, cur_rd);
    chk("err", 32'(err), 32'(cur_e));
    for (int i = 0; i < NREQ; i++)
      if (ack[i]) begin
        ack_log.push_back(i);
        ack_t.push_back(cyc);
      end
  endtask

  task automatic step();
    cycle_begin();
    @(negedge clk);
    cycle_check();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic busy();
    logic b;
    b = (cyc < m_free);
    for (int i = 0; i < NREQ; i++) b = b || pend[i] || (sq[i].size() != 0);
    return b;
  endfunction

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (busy() && n < limit) begin
      step();
      n++;
    end
    checks++;
    assert (!busy())
    else begin
      errors++;
      $error("FAIL drain_timeout: observed=busy after %0d cycles expected=idle", n);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    repeat (2) begin
      @(negedge clk);
      cycle_check();
      @(posedge clk);
      #1;
      cyc++;
    end
    rst    = 1'b1;
    m_free = cyc;
  endtask

  function automatic txn_t mk(input logic [31:0] a, input logic [31:0] d, input logic w);
    txn_t t;
    t.a = a; t.d = d; t.w = w; t.gap = 0; t.drop = 1'b0;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4: t.a = 32'($urandom_range(0, 15));
      5:             t.a = MMIO_LED;
      6:             t.a = MMIO_UART_TX + 32'($urandom_range(0, 2));
      7:             t.a = MMIO_VGADUMP;
      default:       t.a = 32'h0002_0000 + 32'($urandom_range(0, 255));
    endcase
    t.d    = $urandom;
    t.w    = ($urandom_range(0, 2) == 0);
    t.gap  = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 6));
    t.drop = ($urandom_range(0, 7) == 0);
    return t;
  endfunction

  // ---------------- directed + random sequence ----------------
  int we0;

  initial begin
    checks = 0; errors = 0; cyc = 0;
    req = '0; we = '0; addr = '0; wdata = '0;
    ref_wr = '0; ref_led = '0;
    env_clear = 1'b1;
    rst = 1'b0;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      cycle_check();
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    env_clear = 1'b0;
    rst       = 1'b1;
    m_free    = cyc;

    // single read of socram word 5
    sq[0].push_back(mk(32'd5, 32'd0, 1'b0));
    drain(20);
    chk("read5_rdata", rdata, 32'hDEAD_BEEF);
    chk("read5_ack_cnt", 32'(ack_log.size()), 32'd1);

    // LED write from requester 1
    we0 = we_cnt;
    sq[1].push_back(mk(MMIO_LED, 32'h0000_00A5, 1'b1));
    drain(20);
    chk("led_value", env_led, 32'h0000_00A5);
    chk("led_we_cycles", 32'(we_cnt - we0), 32'd1);

    // unmapped read
    sq[0].push_back(mk(32'h0002_0000, 32'd0, 1'b0));
    drain(20);
    chk("unmapped_err", 32'(err), 32'd1);
    chk("unmapped_rdata", rdata, 32'd0);

    // contention right after reset: strict alternation starting at 0
    do_reset();
    for (int n = 0; n < 3; n++) begin
      sq[0].push_back(mk(32'(n), 32'd0, 1'b0));
      sq[1].push_back(mk(32'(n + 8), 32'd0, 1'b0));
    end
    drain(60);
    chk("contend_len", 32'(ack_log.size()), 32'd6);
    for (int j = 0; j < 6 && j < ack_log.size(); j++)
      chk($sformatf("contend_order%0d", j), 32'(ack_log[j]), 32'(j % 2));
    for (int j = 1; j < ack_t.size(); j++)
      chk($sformatf("contend_gap%0d", j), 32'(ack_t[j] - ack_t[j-1]), 32'd3);

    // back-to-back from one requester, including a write
    ack_log.delete(); ack_t.delete();
    sq[0].push_back(mk(32'd3, 32'd0, 1'b0));
    sq[0].push_back(mk(32'd7, 32'd0, 1'b0));
    sq[0].push_back(mk(32'd9, 32'h1234_5678, 1'b1));
    sq[0].push_back(mk(32'd9, 32'd0, 1'b0));
    drain(60);
    chk("b2b_len", 32'(ack_log.size()), 32'd4);
    for (int j = 1; j < ack_t.size(); j++)
      chk($sformatf("b2b_gap%0d", j), 32'(ack_t[j] - ack_t[j-1]), 32'd3);
    chk("b2b_readback", rdata, 32'h1234_5678);

    // reset while requester 1 owns the bus slot
    do_reset();
    sq[0].push_back(mk(32'd2, 32'd0, 1'b0));
    sq[1].push_back(mk(32'd4, 32'd0, 1'b0));
    for (int n = 0; n < 30 && !(cyc == slot_cyc && win == 1); n++) step();
    chk("midslot_reached", 32'(slot_cyc), 32'(cyc));
    #1 rst = 1'b0;
    #1;
    chk("midslot_ack", 32'(ack), 32'd0);
    chk("midslot_addr_b", addr_b, 32'hFFFF_FFFF);
    chk("midslot_data_b_in", data_b_in, 32'd0);
    chk("midslot_data_b_we", data_b_we, 32'd0);
    chk("midslot_rdata", rdata, 32'd0);
    chk("midslot_err", 32'(err), 32'd0);
    chk("midslot_state", 32'(dbg_state), 32'(ST_IDLE));
    model_reset();
    @(negedge clk);
    cycle_check();
    @(posedge clk);
    #1;
    cyc++;
    rst    = 1'b1;
    m_free = cyc;
    sq[1].push_back(mk(32'd6, 32'd0, 1'b0));
    sq[0].push_back(mk(32'd8, 32'd0, 1'b0));
    drain(30);
    chk("post_rst_len", 32'(ack_log.size()), 32'd2);
    if (ack_log.size() > 0) chk("post_rst_first", 32'(ack_log[0]), 32'd0);

    // randomized traffic from both requesters
    for (int n = 0; n < 40; n++)
      for (int i = 0; i < NREQ; i++) sq[i].push_back(rand_txn());
    drain(4000);
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mmbus_arbiter.md
# mmbus_arbiter

Round-robin arbiter that shares the single memory-mapped data bus (port B: socram, uartmm, ledwriter, vgadumper) between up to four requesters, e.g. CPU data port plus a DMA or HLS engine. It serialises requests into one bus slot each, captures read data and the device strobe, and returns a one-cycle acknowledge with data and an unmapped-address error flag. It sits between the requesters and the port-B address decode.

## Interface
- NREQ, 2, number of requesters (2..4)
- IDLE_ADDR, 32'hFFFF_FFFF, address driven while the bus is idle; no device decodes it

- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester request; held with payload until ack
- addr  in  NREQ*32  packed addresses, requester i at [32*i+31:32*i]
- wdata  in  NREQ*32  packed write data
- we  in  NREQ  per-requester write enable
- ack  out  NREQ  one-cycle completion pulse, one-hot
- rdata  out  32  read data, valid with ack
- err  out  1  no device strobed the slot, valid with ack
- addr_b  out  32  shared bus address
- data_b_in  out  32  shared bus write data
- data_b_we  out  32  write enable, only 0 or 1
- data_b  in  32  read data from the bus mux
- strobe_b  in  1  OR of device strobes for addr_b

## Operation
- States: IDLE, SLOT, RESP.
- IDLE: if any req, rr_pick selects winner starting at ptr+1 (mod NREQ); payload registered into addr_b/data_b_in/data_b_we; grant index and ptr updated; -> SLOT. No req: stay, bus idle.
- SLOT: bus driven from registers for exactly one cycle; data_b and strobe_b sampled at end of cycle into rdata/err (err = ~strobe_b; rdata = strobe_b ? data_b : 0); ack[grant] set; bus returns to IDLE_ADDR/0/0; -> RESP.
- RESP: ack pulse visible; ack cleared at end of cycle; -> IDLE.
- Bus idle values: addr_b = IDLE_ADDR, data_b_in = 0, data_b_we = 0 in IDLE and RESP.
- Requester protocol: req and payload stable from assertion until ack cycle inclusive. req still high in the ack cycle is a new request (sampled in the following IDLE cycle).
- req dropped before ack: transaction already registered completes; ack still pulses.
- Writes: err meaningful (unmapped write reported); rdata = data_b sampled during the write slot.
- Arbitration: plain round robin; winner becomes lowest priority. No locking, no bursts.
- rdata and err hold their values until the next SLOT.

## Timing
- Request seen in IDLE at cycle N: bus slot at N+1, ack at N+2, next IDLE at N+3.
- Throughput: one transaction per 3 cycles; contending requesters alternate strictly.
- Worst-case wait for requester i: (NREQ-1) slots = 3*(NREQ-1) cycles before its own slot.
- Reset (async, any state): state IDLE, ack 0, rdata 0, err 0, addr_b IDLE_ADDR, data_b_in 0, data_b_we 0, ptr NREQ-1 (requester 0 wins first). A slot in progress is abandoned with no ack; a write already presented in SLOT may have committed.
- Outputs all registered; no combinational path from req/addr/data_b to any output.

## Structure
- Package mmbus_pkg: state encoding (IDLE, SLOT, RESP), IDLE_ADDR default, MMIO constants 65537..65540 and 65599 for benches.
- Sub-module mmbus_rr_pick: combinational round-robin picker (req vector, ptr) -> one-hot grant and index; reused by future interrupt arbiters.

## Test plan
- Single read: req[0], addr 5, socram word 5 = 0xDEADBEEF -> addr_b=5 at N+1, ack[0] at N+2, rdata=0xDEADBEEF, err=0.
- Write to LED: req[1], addr 65540, wdata 0xA5, we=1 -> data_b_we=1 for exactly one cycle, LED=0xA5, ack[1], err=0.
- Unmapped: req[0] read addr 0x0002_0000 -> ack[0], err=1, rdata=0.
- Contention: req[0] and req[1] held continuously -> grants 0,1,0,1 after reset; ack every 3 cycles; bus idle values between slots.
- Back-to-back: requester keeps req high in ack cycle with new addr -> new slot at ack+2 with the new address, no lost or duplicated acks.
- Reset mid-slot: rst low during SLOT -> all outputs at reset values immediately, no ack after release, next grant goes to requester 0.
